// File: rtl/xor_frame_pkg.sv
// ----------------------------------------------------------------------------
// xor_frame_pkg
//   Shared types and helpers for the streaming XOR frame checksum block.
//   - xf_state_t : frame FSM states (IDLE, ACC, OUT)
//   - xf_cnt_w   : width of a counter able to hold 0..max inclusive
// ----------------------------------------------------------------------------
package xor_frame_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } xf_state_t;

    function automatic int xf_cnt_w(input int max);
        return $clog2(max + 1);
    endfunction

endpackage

// File: rtl/xor_word_using_mux.sv
// ----------------------------------------------------------------------------
// xor_word_using_mux
//   W-bit combinational XOR built only from 2:1 mux cells.
//   Ports:
//     a  in  W  first operand (drives the mux selects)
//     b  in  W  second operand
//     y  out W  a ^ b
// ----------------------------------------------------------------------------
module xor_word_using_mux #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    genvar i;
    for (i = 0; i < W; i++) begin : g_bit
        logic nb;
        // Inverter realised as a mux choosing constant 0 or 1.
        assign nb   = b[i] ? 1'b0 : 1'b1;
        // a=0 passes b, a=1 passes ~b: exactly a XOR b.
        assign y[i] = a[i] ? nb : b[i];
    end

endmodule

// File: rtl/xor_frame_checksum.sv
// ----------------------------------------------------------------------------
// xor_frame_checksum
//   Streaming XOR checksum over framed W-bit words. Each accepted word is
//   XORed into an accumulator; on the last word of a frame the checksum, the
//   word count (saturating at MAX_WORDS) and an overlength flag are registered
//   and presented downstream until accepted.
//
//   Optional feature macro: XOR_FRAME_PARITY_EN
//     When defined, adds output down_parity = ^down_sum, registered with it.
//
//   Ports:
//     clk         in   1        rising-edge clock
//     rst_n       in   1        asynchronous active-low reset
//     up_valid    in   1        upstream word valid
//     up_ready    out  1        block can accept a word (low while a result waits)
//     up_data     in   W        upstream word
//     up_last     in   1        word is the last of its frame
//     down_valid  out  1        checksum result valid
//     down_ready  in   1        downstream accepts the result
//     down_sum    out  W        XOR of all words of the frame
//     down_count  out  CNT      words in frame, saturating at MAX_WORDS
//     down_err    out  1        frame was longer than MAX_WORDS
//     down_parity out  1        (XOR_FRAME_PARITY_EN only) reduction XOR of down_sum
// ----------------------------------------------------------------------------
module xor_frame_checksum
    import xor_frame_pkg::*;
#(
    parameter int W         = 8,
    parameter int MAX_WORDS = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           up_valid,
    output logic                           up_ready,
    input  logic [W-1:0]                   up_data,
    input  logic                           up_last,
    output logic                           down_valid,
    input  logic                           down_ready,
    output logic [W-1:0]                   down_sum,
    output logic [$clog2(MAX_WORDS+1)-1:0] down_count,
    output logic                           down_err
`ifdef XOR_FRAME_PARITY_EN
    ,
    output logic                           down_parity
`endif
);

    localparam int                CNT_W   = xf_cnt_w(MAX_WORDS);
    localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_WORDS);

    xf_state_t        state_q, state_d;
    logic [W-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             down_valid_q, down_valid_d;
    logic [W-1:0]     sum_q, sum_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             derr_q, derr_d;
    logic [W-1:0]     acc_xor_data;
    logic             accept;

    xor_word_using_mux #(.W(W)) u_xor (
        .a (acc_q),
        .b (up_data),
        .y (acc_xor_data)
    );

    // Ready is a pure decode of registered state, never of up_valid.
    assign up_ready = (state_q == IDLE) || (state_q == ACC);
    assign accept   = up_valid && up_ready;

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        down_valid_d = down_valid_q;
        sum_d        = sum_q;
        count_d      = count_q;
        derr_d       = derr_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    acc_d = up_data;
                    cnt_d = CNT_W'(1);
                    err_d = 1'b0;
                end
            end
            ACC: begin
                if (accept) begin
                    acc_d = acc_xor_data;
                    // Already at the limit: this word overflows the frame.
                    if (cnt_q == MAX_CNT) begin
                        err_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            OUT: begin
                if (down_ready) begin
                    state_d      = IDLE;
                    down_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Frame progression is common to IDLE and ACC; the result registers
        // capture the post-update values so they are valid one cycle later.
        if (accept) begin
            state_d = up_last ? OUT : ACC;
            if (up_last) begin
                down_valid_d = 1'b1;
                sum_d        = acc_d;
                count_d      = cnt_d;
                derr_d       = err_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            down_valid_q <= 1'b0;
            sum_q        <= '0;
            count_q      <= '0;
            derr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            down_valid_q <= down_valid_d;
            sum_q        <= sum_d;
            count_q      <= count_d;
            derr_q       <= derr_d;
        end
    end

    assign down_valid = down_valid_q;
    assign down_sum   = sum_q;
    assign down_count = count_q;
    assign down_err   = derr_q;

`ifdef XOR_FRAME_PARITY_EN
    logic parity_q, parity_d;

    assign parity_d = ^sum_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign down_parity = parity_q;
`endif

endmodule

// File: tb/tb_xor_frame_checksum.sv
// ----------------------------------------------------------------------------
// tb_xor_frame_checksum
//   Directed, table-driven bench for xor_frame_checksum (W=8, MAX_WORDS=16),
//   plus hand-written sequences for back-to-back frames, backpressure,
//   mid-frame reset and (with XOR_FRAME_PARITY_EN) the parity output.
// ----------------------------------------------------------------------------
module tb_xor_frame_checksum;

    localparam int W         = 8;
    localparam int MAX_WORDS = 16;
    localparam int CNT_W     = $clog2(MAX_WORDS + 1);
    localparam int NVEC      = 7;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             up_valid;
    logic             up_ready;
    logic [W-1:0]     up_data;
    logic             up_last;
    logic             down_valid;
    logic             down_ready;
    logic [W-1:0]     down_sum;
    logic [CNT_W-1:0] down_count;
    logic             down_err;
`ifdef XOR_FRAME_PARITY_EN
    logic             down_parity;
`endif

    xor_frame_checksum #(.W(W), .MAX_WORDS(MAX_WORDS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .up_data    (up_data),
        .up_last    (up_last),
        .down_valid (down_valid),
        .down_ready (down_ready),
        .down_sum   (down_sum),
        .down_count (down_count),
        .down_err   (down_err)
`ifdef XOR_FRAME_PARITY_EN
        ,
        .down_parity(down_parity)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]        n;
        logic [16:0][7:0]  words;
        logic [7:0]        sum;
        logic [4:0]        cnt;
        logic              err;
    } vec_t;

    vec_t vecs [NVEC];
    int   tests_run = 0;
    int   tests_failed = 0;

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    // Presents one word and returns once it has been accepted (sampled #1
    // after the accepting edge). waited = cycles spent with up_ready low.
    task automatic send_word(input logic [7:0] d, input logic last, output int waited);
        waited   = 0;
        up_valid = 1'b1;
        up_data  = d;
        up_last  = last;
        while (!up_ready && waited < 50) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!up_ready) begin
            tests_run++;
            tests_failed++;
            $display("FAIL send_word_timeout: up_ready stayed 0 for %0d cycles, expected 1", waited);
        end else begin
            @(posedge clk);
            #1;
        end
        up_valid = 1'b0;
        up_last  = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time %0t, expected completion earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        int wt;
        logic [7:0] held_sum;

        // Vector table: words, expected sum / count / err.
        for (int i = 0; i < NVEC; i++) vecs[i] = '0;
        vecs[0].n = 3;  vecs[0].words[0] = 8'hA5; vecs[0].words[1] = 8'h0F; vecs[0].words[2] = 8'hF0;
        vecs[0].sum = 8'h5A; vecs[0].cnt = 5'd3; vecs[0].err = 1'b0;
        vecs[1].n = 1;  vecs[1].words[0] = 8'h3C;
        vecs[1].sum = 8'h3C; vecs[1].cnt = 5'd1; vecs[1].err = 1'b0;
        vecs[2].n = 17; for (int j = 0; j < 17; j++) vecs[2].words[j] = 8'h01;
        vecs[2].sum = 8'h01; vecs[2].cnt = 5'd16; vecs[2].err = 1'b1;
        vecs[3].n = 16; for (int j = 0; j < 16; j++) vecs[3].words[j] = 8'h01;
        vecs[3].sum = 8'h00; vecs[3].cnt = 5'd16; vecs[3].err = 1'b0;
        vecs[4].n = 4;  vecs[4].words[0] = 8'h80; vecs[4].words[1] = 8'h40; vecs[4].words[2] = 8'h20; vecs[4].words[3] = 8'h10;
        vecs[4].sum = 8'hF0; vecs[4].cnt = 5'd4; vecs[4].err = 1'b0;
        vecs[5].n = 2;  vecs[5].words[0] = 8'hFF; vecs[5].words[1] = 8'hFF;
        vecs[5].sum = 8'h00; vecs[5].cnt = 5'd2; vecs[5].err = 1'b0;
        vecs[6].n = 1;  vecs[6].words[0] = 8'h11;
        vecs[6].sum = 8'h11; vecs[6].cnt = 5'd1; vecs[6].err = 1'b0;

        // Reset state
        rst_n = 1'b0; up_valid = 1'b0; up_data = '0; up_last = 1'b0; down_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 0, 32'(down_valid), 32'd0);
        check("rst_sum",   0, 32'(down_sum),   32'd0);
        check("rst_count", 0, 32'(down_count), 32'd0);
        check("rst_err",   0, 32'(down_err),   32'd0);
        check("rst_ready", 0, 32'(up_ready),   32'd1);
        rst_n = 1'b1;

        // Table-driven frames with down_ready held high
        for (int i = 0; i < NVEC; i++) begin
            wt = 0;
            for (int j = 0; j < int'(vecs[i].n); j++) begin
                send_word(vecs[i].words[j], (j == int'(vecs[i].n) - 1), w);
                wt += w;
            end
            check("v_wait",  i, 32'(wt),         32'd0);
            check("v_valid", i, 32'(down_valid), 32'd1);
            check("v_sum",   i, 32'(down_sum),   32'(vecs[i].sum));
            check("v_count", i, 32'(down_count), 32'(vecs[i].cnt));
            check("v_err",   i, 32'(down_err),   32'(vecs[i].err));
            check("v_uprdy", i, 32'(up_ready),   32'd0);
            @(posedge clk);
            #1;
            check("v_vdrop", i, 32'(down_valid), 32'd0);
            check("v_ready", i, 32'(up_ready),   32'd1);
        end

        // Single-word frame followed immediately by the next frame
        send_word(8'h3C, 1'b1, w);
        check("b2b_sum1", 0, 32'(down_sum), 32'h3C);
        @(posedge clk);
        #1;
        send_word(8'h55, 1'b1, w);
        check("b2b_wait",  0, 32'(w),          32'd0);
        check("b2b_valid", 0, 32'(down_valid), 32'd1);
        check("b2b_sum2",  0, 32'(down_sum),   32'h55);
        check("b2b_count", 0, 32'(down_count), 32'd1);
        @(posedge clk);
        #1;

        // Backpressure: result held, upstream word waits and is not lost
        down_ready = 1'b0;
        send_word(8'h12, 1'b0, w);
        send_word(8'h34, 1'b1, w);
        held_sum = 8'h26;
        up_valid = 1'b1; up_data = 8'h77; up_last = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("bp_valid", k, 32'(down_valid), 32'd1);
            check("bp_sum",   k, 32'(down_sum),   32'(held_sum));
            check("bp_count", k, 32'(down_count), 32'd2);
            check("bp_ready", k, 32'(up_ready),   32'd0);
        end
        down_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_rel_valid", 0, 32'(down_valid), 32'd0);
        check("bp_rel_ready", 0, 32'(up_ready),   32'd1);
        @(posedge clk);
        #1;
        up_valid = 1'b0; up_last = 1'b0;
        check("bp_held_valid", 0, 32'(down_valid), 32'd1);
        check("bp_held_sum",   0, 32'(down_sum),   32'h77);
        check("bp_held_count", 0, 32'(down_count), 32'd1);

        // Reset mid-frame after 2 words
        send_word(8'hAA, 1'b0, w);
        send_word(8'hBB, 1'b0, w);
        rst_n = 1'b0;
        #1;
        check("mrst_valid", 0, 32'(down_valid), 32'd0);
        check("mrst_sum",   0, 32'(down_sum),   32'd0);
        check("mrst_count", 0, 32'(down_count), 32'd0);
        check("mrst_err",   0, 32'(down_err),   32'd0);
        check("mrst_ready", 0, 32'(up_ready),   32'd1);
        #1;
        rst_n = 1'b1;
        send_word(8'h11, 1'b1, w);
        check("mrst_new_valid", 0, 32'(down_valid), 32'd1);
        check("mrst_new_sum",   0, 32'(down_sum),   32'h11);
        check("mrst_new_count", 0, 32'(down_count), 32'd1);
        check("mrst_new_err",   0, 32'(down_err),   32'd0);
        @(posedge clk);
        #1;

`ifdef XOR_FRAME_PARITY_EN
        send_word(8'h07, 1'b1, w);
        check("par_07", 0, 32'(down_parity), 32'd1);
        @(posedge clk);
        #1;
        send_word(8'h03, 1'b1, w);
        check("par_03", 0, 32'(down_parity), 32'd0);
        @(posedge clk);
        #1;
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
